// File: rtl/bound_hist_acc.sv
// Per-bound histogram for the PCMA lock calculator: bins a window of samples,
// scans the bins for the maximum and emits one packed frame per window.
module bound_hist_acc #(
  parameter int DATA_WIDTH      = 16,
  parameter int BOUND_WIDTH     = 10,
  parameter int BOUND_NUM       = 32,
  parameter int BOUND_NUM_WIDTH = 5,
  parameter int WIN_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [BOUND_WIDTH-1:0]          sample_i,
  input  logic                            sample_val_i,
  input  logic [WIN_WIDTH-1:0]            win_len_i,
  output logic                            busy_o,
  output logic                            data_val_o,
  output logic [DATA_WIDTH*BOUND_NUM-1:0] data_o,
  output logic [BOUND_NUM_WIDTH-1:0]      max_num_o,
  output logic                            sat_o
);

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    SEARCH = 2'd1,
    SEND   = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0]      BIN_MAX  = {DATA_WIDTH{1'b1}};
  localparam logic [BOUND_NUM_WIDTH-1:0] LAST_IDX = BOUND_NUM_WIDTH'(BOUND_NUM - 1);
  localparam logic [WIN_WIDTH-1:0]       WIN_ONE  = {{(WIN_WIDTH-1){1'b0}}, 1'b1};

  state_e                          state_q;
  logic [DATA_WIDTH-1:0]           bins_q [BOUND_NUM];
  logic [WIN_WIDTH-1:0]            cnt_q;
  logic [WIN_WIDTH-1:0]            win_len_q;
  logic                            sat_q;
  logic [BOUND_NUM_WIDTH-1:0]      scan_q;
  logic [BOUND_NUM_WIDTH-1:0]      max_idx_q;
  logic [DATA_WIDTH-1:0]           max_val_q;
  logic                            busy_q;
  logic                            data_val_q;
  logic [DATA_WIDTH*BOUND_NUM-1:0] data_q;
  logic [BOUND_NUM_WIDTH-1:0]      max_num_q;
  logic                            sat_out_q;

  logic [BOUND_NUM_WIDTH-1:0]      idx_s;
  logic [WIN_WIDTH-1:0]            cnt_d;
  logic [WIN_WIDTH-1:0]            eff_len_s;
  logic [DATA_WIDTH-1:0]           scan_val_s;

  // Bin select, next sample count, effective window length and scanned bin.
  always_comb begin
    idx_s      = sample_i[BOUND_WIDTH-1 -: BOUND_NUM_WIDTH];
    cnt_d      = cnt_q + WIN_ONE;
    eff_len_s  = (win_len_q == {WIN_WIDTH{1'b0}}) ? WIN_ONE : win_len_q;
    scan_val_s = bins_q[scan_q];
  end

  // Accumulate / search / send state machine with registered frame outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ACC;
      for (int i = 0; i < BOUND_NUM; i++) bins_q[i] <= {DATA_WIDTH{1'b0}};
      cnt_q      <= {WIN_WIDTH{1'b0}};
      win_len_q  <= win_len_i;
      sat_q      <= 1'b0;
      scan_q     <= {BOUND_NUM_WIDTH{1'b0}};
      max_idx_q  <= {BOUND_NUM_WIDTH{1'b0}};
      max_val_q  <= {DATA_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      data_val_q <= 1'b0;
      data_q     <= {(DATA_WIDTH*BOUND_NUM){1'b0}};
      max_num_q  <= {BOUND_NUM_WIDTH{1'b0}};
      sat_out_q  <= 1'b0;
    end else begin
      data_val_q <= 1'b0;
      case (state_q)
        ACC: begin
          if (sample_val_i) begin
            // A saturated bin holds its value and flags the window instead.
            if (bins_q[idx_s] == BIN_MAX) begin
              sat_q <= 1'b1;
            end else begin
              bins_q[idx_s] <= bins_q[idx_s] + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end
            cnt_q <= cnt_d;
            if (cnt_d == eff_len_s) begin
              state_q <= SEARCH;
              busy_q  <= 1'b1;
              scan_q  <= {BOUND_NUM_WIDTH{1'b0}};
            end
          end
        end
        SEARCH: begin
          // Strict compare keeps the lowest index on ties.
          if ((scan_q == {BOUND_NUM_WIDTH{1'b0}}) || (scan_val_s > max_val_q)) begin
            max_val_q <= scan_val_s;
            max_idx_q <= scan_q;
          end
          scan_q <= scan_q + {{(BOUND_NUM_WIDTH-1){1'b0}}, 1'b1};
          if (scan_q == LAST_IDX) state_q <= SEND;
        end
        SEND: begin
          for (int i = 0; i < BOUND_NUM; i++) begin
            data_q[i*DATA_WIDTH +: DATA_WIDTH] <= bins_q[i];
            bins_q[i] <= {DATA_WIDTH{1'b0}};
          end
          max_num_q  <= max_idx_q;
          sat_out_q  <= sat_q;
          data_val_q <= 1'b1;
          cnt_q      <= {WIN_WIDTH{1'b0}};
          sat_q      <= 1'b0;
          win_len_q  <= win_len_i;
          busy_q     <= 1'b0;
          state_q    <= ACC;
        end
        default: begin
          state_q <= ACC;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign data_val_o = data_val_q;
  assign data_o     = data_q;
  assign max_num_o  = max_num_q;
  assign sat_o      = sat_out_q;

endmodule

// File: tb/tb_bound_hist_acc.sv
// Directed bench for bound_hist_acc: a default instance and a 4-bit-bin
// instance share one stimulus stream; expected frames are hand computed.
module tb_bound_hist_acc;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [9:0]   sample_i;
  logic         sample_val_i;
  logic [15:0]  win_len_i;
  logic         busy_o, data_val_o, sat_o;
  logic [511:0] data_o;
  logic [4:0]   max_num_o;
  logic         busy4, val4, sat4;
  logic [127:0] data4;
  logic [4:0]   max4;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int t, f0, f1, busy_cnt, nframes, bad;

  always #5 clk = ~clk;

  bound_hist_acc dut (
    .clk(clk), .reset_n(reset_n), .sample_i(sample_i), .sample_val_i(sample_val_i),
    .win_len_i(win_len_i), .busy_o(busy_o), .data_val_o(data_val_o),
    .data_o(data_o), .max_num_o(max_num_o), .sat_o(sat_o)
  );

  bound_hist_acc #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_i(sample_i), .sample_val_i(sample_val_i),
    .win_len_i(win_len_i), .busy_o(busy4), .data_val_o(val4),
    .data_o(data4), .max_num_o(max4), .sat_o(sat4)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] bins16(input int a, input int ca, input int b, input int cb);
    logic [511:0] v;
    v = '0;
    if (a >= 0) v[a*16 +: 16] = 16'(ca);
    if (b >= 0) v[b*16 +: 16] = 16'(cb);
    return v;
  endfunction

  function automatic logic [511:0] bins4(input int a, input int ca);
    logic [511:0] v;
    v = '0;
    v[a*4 +: 4] = 4'(ca);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int bin);
    sample_i     = 10'(bin << 5);
    sample_val_i = 1'b1;
    tick();
    sample_val_i = 1'b0;
  endtask

  // Ticks until data_val_o is seen; budget-bounded.
  task automatic wait_frame(output int l);
    l = 0;
    while (!data_val_o && l < 100) begin
      tick();
      l++;
    end
    chk("frame_seen", {511'd0, data_val_o}, 512'd1);
  endtask

  task automatic no_frame(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (data_val_o) seen++;
    end
    chk(tag, 512'(seen), 512'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_i     = 10'd0;
    sample_val_i = 1'b0;
    win_len_i    = 16'd4;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_data", data_o, 512'd0);
    chk("rst_max", 512'(max_num_o), 512'd0);
    chk("rst_sat", 512'(sat_o), 512'd0);
    chk("rst_val", 512'(data_val_o), 512'd0);
    chk("rst_busy", 512'(busy_o), 512'd0);

    // Four samples into bin 3.
    push(3); push(3); push(3); push(3);
    chk("t1_busy", 512'(busy_o), 512'd1);
    wait_frame(lat);
    chk("t1_latency", 512'(lat), 512'd33);
    chk("t1_data", data_o, bins16(3, 4, -1, 0));
    chk("t1_max", 512'(max_num_o), 512'd3);
    chk("t1_sat", 512'(sat_o), 512'd0);
    chk("t1_data4", 512'(data4), bins4(3, 4));
    tick();
    chk("t1_pulse", 512'(data_val_o), 512'd0);
    chk("t1_busy_low", 512'(busy_o), 512'd0);
    chk("t1_hold", data_o, bins16(3, 4, -1, 0));

    // Tie between bins 5 and 9 resolves to 5; window length 20 for next window.
    push(9); push(5); push(9); push(5);
    win_len_i = 16'd20;
    wait_frame(lat);
    chk("t2_data", data_o, bins16(5, 2, 9, 2));
    chk("t2_max", 512'(max_num_o), 512'd5);

    // Twenty samples into bin 0: the 4-bit instance saturates.
    for (int i = 0; i < 20; i++) push(0);
    win_len_i = 16'd4;
    wait_frame(lat);
    chk("t3_data16", data_o, bins16(0, 20, -1, 0));
    chk("t3_sat16", 512'(sat_o), 512'd0);
    chk("t3_data4", 512'(data4), bins4(0, 15));
    chk("t3_sat4", 512'(sat4), 512'd1);
    chk("t3_max4", 512'(max4), 512'd0);
    tick();
    push(1); push(1); push(1); push(1);
    win_len_i = 16'd2;
    wait_frame(lat);
    chk("t3b_data4", 512'(data4), bins4(1, 4));
    chk("t3b_sat4", 512'(sat4), 512'd0);
    chk("t3b_max4", 512'(max4), 512'd1);
    tick();

    // Continuous valid with window length 2.
    sample_i     = 10'(7 << 5);
    sample_val_i = 1'b1;
    t = 0; f0 = -1; f1 = -1; busy_cnt = 0; nframes = 0; bad = 0;
    while (nframes < 2 && t < 200) begin
      tick();
      t++;
      if (nframes == 1 && busy_o) busy_cnt++;
      if (data_val_o) begin
        if (data_o !== bins16(7, 2, -1, 0)) bad++;
        if (nframes == 0) begin
          f0 = t;
          win_len_i = 16'd4;
        end else begin
          f1 = t;
          sample_val_i = 1'b0;
        end
        nframes++;
      end
    end
    sample_val_i = 1'b0;
    chk("t4_frames", 512'(nframes), 512'd2);
    chk("t4_bin_sum", 512'(bad), 512'd0);
    chk("t4_period", 512'(f1 - f0), 512'd35);
    chk("t4_busy_cycles", 512'(busy_cnt), 512'd33);

    // Reset after 3 of 4 samples discards the window.
    tick();
    push(2); push(2); push(2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_rst_data", data_o, 512'd0);
    chk("t5_rst_max", 512'(max_num_o), 512'd0);
    chk("t5_rst_busy", 512'(busy_o), 512'd0);
    push(2);
    no_frame("t5_no_frame", 40);
    push(2); push(2); push(2);
    win_len_i = 16'd0;
    wait_frame(lat);
    chk("t5_data", data_o, bins16(2, 4, -1, 0));

    // Window length 0 acts as 1; a mid-window length change waits for the next window.
    tick();
    for (int i = 0; i < 5; i++) tick();
    win_len_i = 16'd8;
    tick();
    push(31);
    wait_frame(lat);
    chk("t6_latency", 512'(lat), 512'd33);
    chk("t6_data", data_o, bins16(31, 1, -1, 0));
    chk("t6_max", 512'(max_num_o), 512'd31);
    tick();
    push(4);
    no_frame("t6_len8_pending", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
